// File: rtl/block_dispatcher.sv
// rtl/block_dispatcher.sv - kernel block dispatcher handing fixed-size thread blocks to a pool of cores
module block_dispatcher #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             thread_count,
    input  logic [NUM_CORES-1:0]   core_done,
    output logic [NUM_CORES-1:0]   core_reset,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [NUM_CORES*8-1:0] core_block_id,
    output logic [NUM_CORES*8-1:0] core_thread_count,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_state_t;
    typedef enum logic [1:0] {C_FREE, C_LOAD, C_BUSY} core_state_t;

    top_state_t  state_q, state_d;
    core_state_t core_state_q [NUM_CORES];
    core_state_t core_state_d [NUM_CORES];

    logic [7:0]             tc_q, tc_d;
    logic [8:0]             total_q, total_d;
    logic [8:0]             dispatched_q, dispatched_d;
    logic [8:0]             completed_q, completed_d;
    logic [NUM_CORES-1:0]   core_reset_d, core_start_d;
    logic [NUM_CORES*8-1:0] block_id_d, thread_d;
    logic                   done_d;
    logic                   granted;

    // Block count is computed 9 bits wide so 255 threads round up without wrapping.
    logic [8:0]  launch_blocks;
    logic [15:0] remaining;
    logic [7:0]  blk_threads;

    assign launch_blocks = (9'(thread_count) + 9'(THREADS_PER_BLOCK - 1)) / 9'(THREADS_PER_BLOCK);
    assign remaining     = 16'(tc_q) - 16'(dispatched_q) * 16'(THREADS_PER_BLOCK);
    assign blk_threads   = (remaining > 16'(THREADS_PER_BLOCK)) ? 8'(THREADS_PER_BLOCK) : remaining[7:0];

    // Next-state and next-output logic for the top FSM and every core slot.
    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        total_d      = total_q;
        dispatched_d = dispatched_q;
        completed_d  = completed_q;
        core_reset_d = '0;
        core_start_d = core_start;
        block_id_d   = core_block_id;
        thread_d     = core_thread_count;
        done_d       = (state_q == S_DONE);
        granted      = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            core_state_d[k] = core_state_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tc_d         = thread_count;
                    total_d      = launch_blocks;
                    dispatched_d = '0;
                    completed_d  = '0;
                    core_start_d = '0;
                    for (int k = 0; k < NUM_CORES; k++) begin
                        core_state_d[k] = C_FREE;
                    end
                    state_d = (thread_count == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    case (core_state_q[k])
                        C_LOAD: begin
                            core_state_d[k] = C_BUSY;
                            core_start_d[k] = 1'b1;
                        end
                        C_BUSY: begin
                            if (core_done[k]) begin
                                core_state_d[k] = C_FREE;
                                core_start_d[k] = 1'b0;
                                completed_d     = completed_d + 9'd1;
                            end
                        end
                        default: begin
                            // Only the lowest-index free core is granted, one block per edge.
                            if (!granted && (dispatched_q < total_q)) begin
                                granted              = 1'b1;
                                core_state_d[k]      = C_LOAD;
                                core_reset_d[k]      = 1'b1;
                                block_id_d[8*k +: 8] = dispatched_q[7:0];
                                thread_d[8*k +: 8]   = blk_threads;
                                dispatched_d         = dispatched_q + 9'd1;
                            end
                        end
                    endcase
                end
                if (completed_d == total_q) begin
                    state_d      = S_DONE;
                    core_start_d = '0;
                    core_reset_d = '0;
                end
            end
            S_DONE: begin
                core_start_d = '0;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            tc_q              <= '0;
            total_q           <= '0;
            dispatched_q      <= '0;
            completed_q       <= '0;
            core_reset        <= '0;
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            done              <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                core_state_q[k] <= C_FREE;
            end
        end else begin
            state_q           <= state_d;
            tc_q              <= tc_d;
            total_q           <= total_d;
            dispatched_q      <= dispatched_d;
            completed_q       <= completed_d;
            core_reset        <= core_reset_d;
            core_start        <= core_start_d;
            core_block_id     <= block_id_d;
            core_thread_count <= thread_d;
            done              <= done_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                core_state_q[k] <= core_state_d[k];
            end
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// tb/tb_block_dispatcher.sv - directed self-checking bench for block_dispatcher
module tb_block_dispatcher;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count;
    logic [3:0]  core_done;
    logic [3:0]  core_reset;
    logic [3:0]  core_start;
    logic [31:0] core_block_id;
    logic [31:0] core_thread_count;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic mon_core3 = 1'b0;
    logic mon_none  = 1'b0;
    logic bad3      = 1'b0;
    logic bad_any   = 1'b0;

    block_dispatcher #(.NUM_CORES(4), .THREADS_PER_BLOCK(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_reset        (core_reset),
        .core_start        (core_start),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sticky watchers for outputs that must never pulse during a window.
    always @(negedge clk) begin
        if (mon_core3 && (core_reset[3] || core_start[3])) bad3 <= 1'b1;
        if (mon_none && ((|core_reset) || (|core_start))) bad_any <= 1'b1;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bid(input int k);
        return core_block_id[8*k +: 8];
    endfunction

    function automatic logic [7:0] thr(input int k);
        return core_thread_count[8*k +: 8];
    endfunction

    initial begin
        logic found;
        reset        = 1'b0;
        start        = 1'b0;
        thread_count = 8'd0;
        core_done    = 4'b0000;
        tick();
        tick();
        chk("rst_core_reset", 32'(core_reset), 32'h0);
        chk("rst_core_start", 32'(core_start), 32'h0);
        chk("rst_block_id", core_block_id, 32'h0);
        chk("rst_thread", core_thread_count, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick();

        // 16 threads: four blocks to four cores on consecutive edges.
        start = 1'b1; thread_count = 8'd16;
        tick();
        chk("a_e0_reset", 32'(core_reset), 32'h0);
        tick();
        chk("a_e1_reset", 32'(core_reset), 32'b0001);
        chk("a_e1_start", 32'(core_start), 32'b0000);
        tick();
        chk("a_e2_reset", 32'(core_reset), 32'b0010);
        chk("a_e2_start", 32'(core_start), 32'b0001);
        tick();
        chk("a_e3_reset", 32'(core_reset), 32'b0100);
        tick();
        chk("a_e4_reset", 32'(core_reset), 32'b1000);
        chk("a_e4_start", 32'(core_start), 32'b0111);
        chk("a_e4_ids", core_block_id, 32'h03020100);
        chk("a_e4_thr", core_thread_count, 32'h04040404);
        core_done = 4'b0001;
        tick();
        chk("a_e5_start", 32'(core_start), 32'b1110);
        core_done = 4'b0010;
        tick();
        chk("a_e6_start", 32'(core_start), 32'b1100);
        core_done = 4'b0100;
        tick();
        core_done = 4'b1000;
        tick();
        core_done = 4'b0000;
        chk("a_e8_start", 32'(core_start), 32'h0);
        chk("a_e8_done", 32'(done), 32'h0);
        tick();
        chk("a_e9_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        tick();
        chk("a_idle_done", 32'(done), 32'h0);

        // 10 threads: blocks of 4,4,2; core 3 untouched and keeps its old fields.
        mon_core3 = 1'b1;
        start = 1'b1; thread_count = 8'd10;
        tick(); tick(); tick(); tick();
        chk("b_e3_reset", 32'(core_reset), 32'b0100);
        chk("b_e3_ids", core_block_id, 32'h03020100);
        chk("b_e3_thr", core_thread_count, 32'h04020404);
        tick();
        chk("b_e4_start", 32'(core_start), 32'b0111);
        core_done = 4'b0111;
        tick();
        chk("b_e5_start", 32'(core_start), 32'h0);
        tick();
        chk("b_e6_done", 32'(done), 32'h1);
        start = 1'b0; core_done = 4'b0000;
        tick(); tick();
        mon_core3 = 1'b0;
        chk("b_core3_quiet", 32'(bad3), 32'h0);

        // 24 threads: cores 0 and 2 finish together, then are refilled core 0 first.
        start = 1'b1; thread_count = 8'd24;
        for (int i = 0; i < 6; i++) tick();
        chk("c_e5_start", 32'(core_start), 32'b1111);
        core_done = 4'b0101;
        tick();
        core_done = 4'b0000;
        chk("c_e6_start", 32'(core_start), 32'b1010);
        chk("c_e6_reset", 32'(core_reset), 32'h0);
        tick();
        chk("c_e7_reset", 32'(core_reset), 32'b0001);
        chk("c_e7_id0", 32'(bid(0)), 32'd4);
        tick();
        chk("c_e8_reset", 32'(core_reset), 32'b0100);
        chk("c_e8_id2", 32'(bid(2)), 32'd5);
        chk("c_e8_start", 32'(core_start), 32'b1011);
        tick();
        core_done = 4'b1111;
        tick();
        core_done = 4'b0000;
        chk("c_e10_start", 32'(core_start), 32'h0);
        tick();
        chk("c_e11_done", 32'(done), 32'h1);
        start = 1'b0;
        tick(); tick();

        // 40 threads with only core 1 completing: blocks 4..9 all land on core 1.
        start = 1'b1; thread_count = 8'd40; core_done = 4'b0010;
        tick(); tick(); tick(); tick(); tick();
        for (int b = 4; b < 10; b++) begin
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                tick();
                if (core_reset != 4'b0000) found = 1'b1;
            end
            chk($sformatf("d_seen_%0d", b), 32'(found), 32'h1);
            chk($sformatf("d_reset_%0d", b), 32'(core_reset), 32'b0010);
            chk($sformatf("d_id1_%0d", b), 32'(bid(1)), b);
            chk($sformatf("d_thr1_%0d", b), 32'(thr(1)), 32'd4);
        end
        for (int i = 0; i < 5; i++) tick();
        chk("d_not_done", 32'(done), 32'h0);
        chk("d_start_rest", 32'(core_start), 32'b1101);
        core_done = 4'b1111;
        tick();
        core_done = 4'b0000;
        chk("d_final_start", 32'(core_start), 32'h0);
        tick();
        chk("d_done", 32'(done), 32'h1);
        start = 1'b0;
        tick(); tick();

        // Zero threads: straight to DONE, nothing dispatched.
        mon_none = 1'b1;
        start = 1'b1; thread_count = 8'd0;
        tick();
        chk("e_e0_done", 32'(done), 32'h0);
        tick();
        chk("e_e1_done", 32'(done), 32'h1);
        start = 1'b0;
        tick(); tick();
        chk("e_idle_done", 32'(done), 32'h0);
        mon_none = 1'b0;
        chk("e_no_pulses", 32'(bad_any), 32'h0);

        // Asynchronous reset mid-run, then a fresh 4-thread launch.
        start = 1'b1; thread_count = 8'd16;
        tick(); tick(); tick();
        chk("f_pre_start", 32'(core_start), 32'b0001);
        #2 reset = 1'b0;
        #1;
        chk("f_async_reset", 32'(core_reset), 32'h0);
        chk("f_async_start", 32'(core_start), 32'h0);
        chk("f_async_ids", core_block_id, 32'h0);
        chk("f_async_thr", core_thread_count, 32'h0);
        chk("f_async_done", 32'(done), 32'h0);
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("f_idle_reset", 32'(core_reset), 32'h0);
        chk("f_idle_start", 32'(core_start), 32'h0);
        start = 1'b1; thread_count = 8'd4;
        tick(); tick();
        chk("f_reset0", 32'(core_reset), 32'b0001);
        chk("f_id0", 32'(bid(0)), 32'd0);
        chk("f_thr0", 32'(thr(0)), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_dispatcher.md
BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 4: number of cores served.
REQ-002 Parameter THREADS_PER_BLOCK, default 4: maximum threads per dispatched block.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  kernel launch level; held high by host until done seen.
REQ-006 thread_count  in  8  total kernel threads, sampled only on launch.
REQ-007 core_done  in  NUM_CORES  per-core block-complete level.
REQ-008 core_reset  out  NUM_CORES  per-core one-cycle reset pulse before each block.
REQ-009 core_start  out  NUM_CORES  per-core run level, held while a block executes.
REQ-010 core_block_id  out  NUM_CORES*8  flattened, core k in bits [8k+7:8k]; block index assigned to core k.
REQ-011 core_thread_count  out  NUM_CORES*8  flattened like core_block_id; threads in core k's block.
REQ-012 done  out  1  kernel complete.

Function
REQ-013 Top FSM states SHALL be IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-014 IDLE: at an edge with start=1, latch thread_count and total_blocks = ceil(thread_count/THREADS_PER_BLOCK), computed at 9-bit width, no overflow at 255; go to RUN.
REQ-015 IDLE with start=1 and thread_count=0 SHALL go directly to DONE, dispatching nothing.
REQ-016 Per-core state SHALL be FREE, LOAD or BUSY; all cores are FREE on leaving IDLE.
REQ-017 RUN: at each edge where dispatched < total_blocks and at least one core is FREE, the lowest-index FREE core k SHALL be assigned; at most one assignment per edge.
REQ-018 Assignment: core k enters LOAD; core_block_id[k] = dispatched; core_thread_count[k] = min(THREADS_PER_BLOCK, thread_count - dispatched*THREADS_PER_BLOCK); dispatched increments.
REQ-019 LOAD lasts exactly one cycle with core_reset[k]=1 and core_start[k]=0; the next edge moves core k to BUSY.
REQ-020 BUSY: core_start[k]=1 held; at an edge with core_done[k]=1, core k returns to FREE and core_start[k] drops the next cycle.
REQ-021 core_done[k] while core k is FREE or LOAD SHALL be ignored.
REQ-022 completed SHALL increment by the number of cores completing at the same edge, so simultaneous completions are all counted.
REQ-023 A core freed at edge E SHALL NOT be reassigned before edge E+1.
REQ-024 RUN -> DONE at the edge where completed reaches total_blocks.
REQ-025 DONE: done=1 and all core_start/core_reset = 0; start=0 at an edge returns to IDLE with done=0 the next cycle.
REQ-026 start deassertion during RUN SHALL be ignored; the kernel runs to completion.
REQ-027 core_block_id and core_thread_count SHALL hold their values until core k is reassigned.
REQ-028 Latency: start sampled at edge E0; first core_reset pulse is high after E1; first core_start is high after E2.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, all cores FREE, all counters 0, and core_reset, core_start, core_block_id, core_thread_count and done all 0.
REQ-030 Reset asserted mid-RUN SHALL abandon the kernel; after release the block waits in IDLE for a new start.

Verification
REQ-031 thread_count=16, NUM_CORES=4, TPB=4, cores report done 3 cycles after start -> block ids 0,1,2,3 go to cores 0..3 on consecutive edges, each thread count 4; done=1 after the 4th completion.
REQ-032 thread_count=10 -> 3 blocks with thread counts 4,4,2; core 3 is never reset or started.
REQ-033 thread_count=40 (10 blocks), only core 1 ever completes -> blocks 4..9 are all issued to core 1 in order; done only after 10 completions.
REQ-034 Cores 0 and 2 assert core_done on the same edge -> completed increases by 2; both cores are reassigned on the next two edges, core 0 first.
REQ-035 thread_count=0 -> done=1 two cycles after start; no core_reset or core_start pulses; start=0 returns the block to IDLE.
REQ-036 reset=0 asynchronously mid-RUN -> all outputs 0 before the next edge; a following start with thread_count=4 dispatches block 0 to core 0.
